// File: rtl/iot_zone_monitor.sv
// ---------------------------------------------------------------------------
// iot_zone_monitor
//   Multi-zone active IoT device monitor. Each zone keeps an up/down device
//   counter (wrap-around or saturating), a sticky boundary flag and a
//   per-zone synchronous clear. A registered aggregate total across all zones
//   drives an occupancy alarm with hysteresis.
//
// Ports
//   clk          in   1               system clock, rising edge
//   rst          in   1               synchronous reset, active low
//   change       in   N_ZONES         per-zone count enable
//   on_off       in   N_ZONES         per-zone direction (1 = up, 0 = down)
//   clr_zone     in   N_ZONES         per-zone clear of counter and flag
//   zone_count   out  N_ZONES*WIDTH   packed counters, zone i at [i*WIDTH +: WIDTH]
//   total_count  out  TW              sum of all zone counters
//   ev_flag      out  N_ZONES         sticky per-zone boundary flag
//   alarm        out  1               hysteretic occupancy alarm
// ---------------------------------------------------------------------------
module iot_zone_monitor #(
  parameter int unsigned N_ZONES   = 4,
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned SATURATE  = 0,
  parameter int unsigned HI_THRESH = 600,
  parameter int unsigned LO_THRESH = 500
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [N_ZONES-1:0]                     change,
  input  logic [N_ZONES-1:0]                     on_off,
  input  logic [N_ZONES-1:0]                     clr_zone,
  output logic [N_ZONES*WIDTH-1:0]               zone_count,
  output logic [WIDTH+$clog2(N_ZONES)-1:0]       total_count,
  output logic [N_ZONES-1:0]                     ev_flag,
  output logic                                   alarm
);

  localparam int unsigned TW = WIDTH + $clog2(N_ZONES);

  localparam logic [TW-1:0]    HI_T    = TW'(HI_THRESH);
  localparam logic [TW-1:0]    LO_T    = TW'(LO_THRESH);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_ALARM = 1'b1;

  logic [WIDTH-1:0]   cnt_q    [N_ZONES];
  logic [WIDTH-1:0]   cnt_next [N_ZONES];
  logic [N_ZONES-1:0] ev_q;
  logic [N_ZONES-1:0] ev_next;
  logic [TW-1:0]      total_q;
  logic [TW-1:0]      total_next;
  logic [0:0]         state_q;
  logic [0:0]         state_next;

  // Per-zone next state (clear > change > hold) and the aggregate of the
  // next-state values, so the registered total lines up with zone_count.
  always_comb begin
    cnt_next   = cnt_q;
    ev_next    = ev_q;
    total_next = '0;
    for (int unsigned i = 0; i < N_ZONES; i++) begin
      if (clr_zone[i]) begin
        cnt_next[i] = '0;
        ev_next[i]  = 1'b0;
      end else if (change[i]) begin
        if (on_off[i]) begin
          if (cnt_q[i] == CNT_MAX) begin
            ev_next[i]  = 1'b1;
            cnt_next[i] = (SATURATE != 0) ? CNT_MAX : '0;
          end else begin
            cnt_next[i] = cnt_q[i] + ONE;
          end
        end else begin
          if (cnt_q[i] == '0) begin
            ev_next[i]  = 1'b1;
            cnt_next[i] = (SATURATE != 0) ? '0 : CNT_MAX;
          end else begin
            cnt_next[i] = cnt_q[i] - ONE;
          end
        end
      end
      total_next = total_next + TW'(cnt_next[i]);
    end
  end

  // Alarm hysteresis works on the registered total, giving one cycle of
  // latency after the qualifying total becomes visible.
  always_comb begin
    state_next = state_q;
    case (state_q)
      ST_IDLE:  if (total_q >= HI_T) state_next = ST_ALARM;
      ST_ALARM: if (total_q <= LO_T) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < N_ZONES; i++) begin
        cnt_q[i] <= '0;
      end
      ev_q    <= '0;
      total_q <= '0;
      state_q <= ST_IDLE;
    end else begin
      cnt_q   <= cnt_next;
      ev_q    <= ev_next;
      total_q <= total_next;
      state_q <= state_next;
    end
  end

  always_comb begin
    zone_count = '0;
    for (int unsigned i = 0; i < N_ZONES; i++) begin
      zone_count[i*WIDTH +: WIDTH] = cnt_q[i];
    end
  end

  assign total_count = total_q;
  assign ev_flag     = ev_q;
  assign alarm       = (state_q == ST_ALARM);

endmodule

// File: tb/tb_iot_zone_monitor.sv
// ---------------------------------------------------------------------------
// tb_iot_zone_monitor
//   Drives one wrap-around and one saturating instance with identical
//   stimulus. A reference model computes expected outputs when stimulus is
//   applied; they are queued and compared after the clock edge.
// ---------------------------------------------------------------------------
module tb_iot_zone_monitor;

  localparam int NZ = 4;
  localparam int W  = 8;
  localparam int TW = 10;
  localparam int MAXV = 255;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [NZ-1:0] change = '0;
  logic [NZ-1:0] on_off = '0;
  logic [NZ-1:0] clr_zone = '0;

  logic [NZ*W-1:0] zc_w, zc_s;
  logic [TW-1:0]   tot_w, tot_s;
  logic [NZ-1:0]   ev_w, ev_s;
  logic            al_w, al_s;

  iot_zone_monitor #(.N_ZONES(NZ), .WIDTH(W), .SATURATE(0),
                     .HI_THRESH(600), .LO_THRESH(500)) dut_wrap (
    .clk(clk), .rst(rst), .change(change), .on_off(on_off),
    .clr_zone(clr_zone), .zone_count(zc_w), .total_count(tot_w),
    .ev_flag(ev_w), .alarm(al_w));

  iot_zone_monitor #(.N_ZONES(NZ), .WIDTH(W), .SATURATE(1),
                     .HI_THRESH(600), .LO_THRESH(500)) dut_sat (
    .clk(clk), .rst(rst), .change(change), .on_off(on_off),
    .clr_zone(clr_zone), .zone_count(zc_s), .total_count(tot_s),
    .ev_flag(ev_s), .alarm(al_s));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] zc;
    logic [9:0]  tot;
    logic [3:0]  ev;
    logic        al;
  } exp_t;

  exp_t exp_q [$];
  exp_t exp_sat_q [$];

  int checks   = 0;
  int failures = 0;

  // Reference state, index 0 = wrap-around, 1 = saturating
  int m_cnt [2][NZ];
  bit m_ev  [2][NZ];
  int m_tot [2];
  bit m_al  [2];

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d (0x%0h) expected=%0d (0x%0h) t=%0t",
               tag, got, got, exp, exp, $time);
    end
  endtask

  function automatic exp_t model_step(input int s, input bit r,
                                      input logic [NZ-1:0] chg,
                                      input logic [NZ-1:0] dir,
                                      input logic [NZ-1:0] clr);
    exp_t e;
    int sum;
    // Alarm uses the total registered before this edge
    if (!r) m_al[s] = 1'b0;
    else if (!m_al[s] && m_tot[s] >= 600) m_al[s] = 1'b1;
    else if (m_al[s] && m_tot[s] <= 500) m_al[s] = 1'b0;
    sum = 0;
    for (int z = 0; z < NZ; z++) begin
      if (!r) begin
        m_cnt[s][z] = 0; m_ev[s][z] = 1'b0;
      end else if (clr[z]) begin
        m_cnt[s][z] = 0; m_ev[s][z] = 1'b0;
      end else if (chg[z]) begin
        if (dir[z]) begin
          if (m_cnt[s][z] == MAXV) begin
            m_ev[s][z] = 1'b1;
            m_cnt[s][z] = (s == 1) ? MAXV : 0;
          end else m_cnt[s][z]++;
        end else begin
          if (m_cnt[s][z] == 0) begin
            m_ev[s][z] = 1'b1;
            m_cnt[s][z] = (s == 1) ? 0 : MAXV;
          end else m_cnt[s][z]--;
        end
      end
      sum += m_cnt[s][z];
    end
    m_tot[s] = r ? sum : 0;
    e.zc = '0;
    e.ev = '0;
    for (int z = 0; z < NZ; z++) begin
      e.zc[z*8 +: 8] = m_cnt[s][z][7:0];
      e.ev[z] = m_ev[s][z];
    end
    e.tot = m_tot[s][9:0];
    e.al  = m_al[s];
    return e;
  endfunction

  // One clock: drive, push expectations, wait for the edge, pop and compare
  task automatic step(input bit r, input logic [NZ-1:0] chg,
                      input logic [NZ-1:0] dir, input logic [NZ-1:0] clr);
    exp_t ew, es;
    @(negedge clk);
    rst = r; change = chg; on_off = dir; clr_zone = clr;
    exp_q.push_back(model_step(0, r, chg, dir, clr));
    exp_sat_q.push_back(model_step(1, r, chg, dir, clr));
    @(posedge clk);
    #1;
    ew = exp_q.pop_front();
    es = exp_sat_q.pop_front();
    check_val("wrap_zone_count", zc_w, ew.zc);
    check_val("wrap_total",      32'(tot_w), 32'(ew.tot));
    check_val("wrap_ev_flag",    32'(ev_w), 32'(ew.ev));
    check_val("wrap_alarm",      32'(al_w), 32'(ew.al));
    check_val("sat_zone_count",  zc_s, es.zc);
    check_val("sat_total",       32'(tot_s), 32'(es.tot));
    check_val("sat_ev_flag",     32'(ev_s), 32'(es.ev));
    check_val("sat_alarm",       32'(al_s), 32'(es.al));
  endtask

  initial begin
    #10ms;
    $display("FAIL watchdog simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int s = 0; s < 2; s++) begin
      m_tot[s] = 0; m_al[s] = 1'b0;
      for (int z = 0; z < NZ; z++) begin
        m_cnt[s][z] = 0; m_ev[s][z] = 1'b0;
      end
    end

    // Initial reset
    step(1'b0, '0, '0, '0);
    check_val("reset_zone_count", zc_w, 32'd0);
    check_val("reset_alarm", 32'(al_w), 32'd0);

    // T1: random activity then a single reset edge
    for (int k = 0; k < 30; k++)
      step(1'b1, 4'($urandom), 4'($urandom), 4'($urandom_range(0, 15) == 0 ? 1 : 0));
    step(1'b0, 4'hF, 4'hF, '0);
    check_val("t1_zone_count", zc_w, 32'd0);
    check_val("t1_total", 32'(tot_s), 32'd0);
    check_val("t1_ev", 32'(ev_w), 32'd0);

    // T2: zone0 up x3, zone1 down x1, concurrently
    step(1'b1, 4'b0011, 4'b0001, '0);
    step(1'b1, 4'b0001, 4'b0001, '0);
    step(1'b1, 4'b0001, 4'b0001, '0);
    check_val("t2_zone0", 32'(zc_w[7:0]), 32'd3);
    check_val("t2_zone1", 32'(zc_w[15:8]), 32'd255);
    check_val("t2_ev", 32'(ev_w), 32'b0010);
    check_val("t2_total", 32'(tot_w), 32'd258);

    // T3: saturating boundaries on zone1 (down at 0) and zone2 (up at max)
    step(1'b0, '0, '0, '0);
    step(1'b1, 4'b0010, 4'b0000, '0);
    check_val("t3_sat_zone1", 32'(zc_s[15:8]), 32'd0);
    check_val("t3_sat_ev1", 32'(ev_s[1]), 32'd1);
    for (int k = 0; k < 255; k++) step(1'b1, 4'b0100, 4'b0100, '0);
    check_val("t3_sat_ev2_before", 32'(ev_s[2]), 32'd0);
    step(1'b1, 4'b0100, 4'b0100, '0);
    check_val("t3_sat_zone2", 32'(zc_s[23:16]), 32'd255);
    check_val("t3_sat_ev2", 32'(ev_s[2]), 32'd1);
    check_val("t3_wrap_zone2", 32'(zc_w[23:16]), 32'd0);

    // T4: alarm hysteresis
    step(1'b0, '0, '0, '0);
    for (int k = 0; k < 200; k++) step(1'b1, 4'b0111, 4'b0111, '0);
    check_val("t4_total600", 32'(tot_w), 32'd600);
    check_val("t4_alarm_latency", 32'(al_w), 32'd0);
    step(1'b1, '0, '0, '0);
    check_val("t4_alarm_set", 32'(al_w), 32'd1);
    for (int k = 0; k < 99; k++) step(1'b1, 4'b0001, 4'b0000, '0);
    check_val("t4_total501", 32'(tot_w), 32'd501);
    step(1'b1, '0, '0, '0);
    check_val("t4_alarm_hold501", 32'(al_w), 32'd1);
    step(1'b1, 4'b0001, 4'b0000, '0);
    check_val("t4_total500", 32'(tot_w), 32'd500);
    check_val("t4_alarm_still1", 32'(al_w), 32'd1);
    step(1'b1, '0, '0, '0);
    check_val("t4_alarm_clear", 32'(al_w), 32'd0);

    // T5: clear wins over simultaneous change; other zones keep counting
    step(1'b0, '0, '0, '0);
    step(1'b1, 4'b0100, 4'b0000, '0);
    for (int k = 0; k < 11; k++) step(1'b1, 4'b0100, 4'b0100, '0);
    check_val("t5_wrap_zone2", 32'(zc_w[23:16]), 32'd10);
    check_val("t5_wrap_ev2", 32'(ev_w[2]), 32'd1);
    step(1'b1, 4'b1101, 4'b1101, 4'b0100);
    check_val("t5_zone2_clr", 32'(zc_w[23:16]), 32'd0);
    check_val("t5_ev2_clr", 32'(ev_w[2]), 32'd0);
    check_val("t5_zone0", 32'(zc_w[7:0]), 32'd1);
    step(1'b1, 4'b1001, 4'b1001, '0);

    // T6: reset while alarmed and counting, then resume
    step(1'b0, '0, '0, '0);
    for (int k = 0; k < 210; k++) step(1'b1, 4'b0111, 4'b0111, '0);
    check_val("t6_alarm_pre", 32'(al_w), 32'd1);
    step(1'b0, 4'b1111, 4'b1111, '0);
    check_val("t6_zone_count", zc_w, 32'd0);
    check_val("t6_alarm", 32'(al_w), 32'd0);
    check_val("t6_total", 32'(tot_w), 32'd0);
    step(1'b1, 4'b0001, 4'b0001, '0);
    check_val("t6_resume", 32'(zc_w[7:0]), 32'd1);
    step(1'b1, '0, '0, '0);
    check_val("t6_alarm_stays0", 32'(al_w), 32'd0);

    // Random mix with occasional clears and resets
    for (int k = 0; k < 400; k++)
      step($urandom_range(0, 63) != 0, 4'($urandom), 4'($urandom),
           4'($urandom_range(0, 7) == 0 ? $urandom : 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
